// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one big-endian, byte-addressed data-memory port
// between requester 0 (pipeline MEM stage) and requester 1 (loader/debug).
// One access at a time: IDLE -> ACCESS -> DONE -> IDLE, round-robin on ties.
// Misaligned or out-of-range word accesses are flagged and never reach memory.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   rN_req/we/addr/wdata (N=0,1)   request, held until rN_gnt
//   rN_gnt                         one-cycle pulse in the ACCESS cycle
//   rN_done/err/rdata              completion pulse, error flag, read data
//   mem_addr/wdata/we/re           memory port (driven only during ACCESS)
//   mem_rdata                      combinational read data from memory
//   busy                           high whenever the FSM is not IDLE
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Highest legal word address; compared unsigned at full width so large
  // addresses never wrap into range.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state_q, state_d;
  logic              last_q, last_d;   // requester granted most recently
  logic              win_q, win_d;     // requester owning the current access
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              pick;
  logic              sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              acc, dn;

  // Winner: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick      = (r0_req && r1_req) ? ~last_q : (r1_req && !r0_req);
    sel_we    = pick ? r1_we    : r0_we;
    sel_addr  = pick ? r1_addr  : r0_addr;
    sel_wdata = pick ? r1_wdata : r0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
  end

  assign acc = (state_q == ACCESS);
  assign dn  = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_d = ACCESS;
          win_d   = pick;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = sel_err;
        end
      end
      ACCESS: begin
        state_d = DONE;
        // Writes and errored accesses capture 0 so stale data never leaks.
        if (win_q) rdata1_d = mem_re ? mem_rdata : '0;
        else       rdata0_d = mem_re ? mem_rdata : '0;
      end
      DONE: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign r0_gnt   = acc & ~win_q;
  assign r1_gnt   = acc &  win_q;
  assign r0_done  = dn  & ~win_q;
  assign r1_done  = dn  &  win_q;
  assign r0_err   = dn  & ~win_q & err_q;
  assign r1_err   = dn  &  win_q & err_q;
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;

  // Enables are gated by rst_n so a reset landing in ACCESS cancels the
  // memory operation in that same cycle.
  assign mem_we    = rst_n & acc & ~err_q &  we_q;
  assign mem_re    = rst_n & acc & ~err_q & ~we_q;
  assign mem_addr  = acc ? addr_q  : '0;
  assign mem_wdata = acc ? wdata_q : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;
  logic        mem_init = 1'b1;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0, re_cnt = 0, gnt1_cnt = 0, done1_cnt = 0, both_cnt = 0;

  logic [7:0] mem [0:255];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory; preloaded with mem[i] = i.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (mem_we && mem_addr <= 32'd252) begin
      mem[mem_addr[7:0]]        <= mem_wdata[31:24];
      mem[mem_addr[7:0] + 8'd1] <= mem_wdata[23:16];
      mem[mem_addr[7:0] + 8'd2] <= mem_wdata[15:8];
      mem[mem_addr[7:0] + 8'd3] <= mem_wdata[7:0];
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr <= 32'd252)
      mem_rdata = {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                   mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (r1_gnt) gnt1_cnt <= gnt1_cnt + 1;
    if (r1_done) done1_cnt <= done1_cnt + 1;
    if ((r0_gnt && r1_gnt) || (r0_done && r1_done)) both_cnt <= both_cnt + 1;
  end

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Single access through one requester, checking the gnt/done timeline,
  // that the address stays latched after inputs change, and the result.
  task automatic access(input int rq, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input logic chk_rd,
                        input string name);
    logic g, d, e;
    logic [31:0] rd;
    @(posedge clk); #1;
    if (rq == 0) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
    else         begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
    @(posedge clk);
    @(negedge clk);
    g = (rq == 0) ? r0_gnt : r1_gnt;
    d = (rq == 0) ? r0_done : r1_done;
    checks++;
    if (g !== 1'b1 || d !== 1'b0) begin
      errors++; $display("FAIL %s gnt: got gnt=%b done=%b want gnt=1 done=0", name, g, d);
    end
    // Requester drops req and scribbles its inputs; the access must not notice.
    r0_req = 0; r1_req = 0;
    r0_addr = 32'h40; r1_addr = 32'h40; r0_wdata = 32'h0; r1_wdata = 32'h0;
    #1;
    checks++;
    if (mem_addr !== addr) begin
      errors++; $display("FAIL %s latch: got mem_addr=%h want %h", name, mem_addr, addr);
    end
    @(negedge clk);
    g  = (rq == 0) ? r0_gnt : r1_gnt;
    d  = (rq == 0) ? r0_done : r1_done;
    e  = (rq == 0) ? r0_err : r1_err;
    rd = (rq == 0) ? r0_rdata : r1_rdata;
    checks++;
    if (d !== 1'b1 || g !== 1'b0 || e !== exp_err) begin
      errors++; $display("FAIL %s done: got done=%b gnt=%b err=%b want 1 0 %b", name, d, g, e, exp_err);
    end
    if (chk_rd) begin
      checks++;
      if (rd !== exp_rdata) begin
        errors++; $display("FAIL %s rdata: got %h want %h", name, rd, exp_rdata);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s idle: got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    r0_req = 1; r0_addr = 32'h8;  // request held in reset must do nothing
    rst_n = 0;
    repeat (2) @(posedge clk);
    mem_init = 0;
    @(negedge clk);
    checks++;
    if ({busy, r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, mem_we, mem_re} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000000",
        {busy, r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, mem_we, mem_re});
    end
    checks++;
    if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got r0=%h r1=%h addr=%h wdata=%h want 0",
        r0_rdata, r1_rdata, mem_addr, mem_wdata);
    end
    r0_req = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_write_read();
    int w0, r0c;
    w0 = we_cnt; r0c = re_cnt;
    access(0, 1'b1, 32'd8, 32'h11223344, 1'b0, 32'h0, 1'b0, "wr8");
    access(0, 1'b0, 32'd8, 32'h0, 1'b0, 32'h11223344, 1'b1, "rd8");
    @(posedge clk); #2;
    checks++;
    if (word_at(8) !== 32'h11223344) begin
      errors++; $display("FAIL wr8_mem: got %h want 11223344", word_at(8));
    end
    checks++;
    if (we_cnt - w0 !== 1 || re_cnt - r0c !== 1) begin
      errors++; $display("FAIL wr8_pulses: got we=%0d re=%0d want 1 1", we_cnt - w0, re_cnt - r0c);
    end
  endtask

  task automatic test_misaligned();
    int w0;
    w0 = we_cnt;
    access(1, 1'b1, 32'd6, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, "mis6");
    @(posedge clk); #2;
    checks++;
    if (we_cnt !== w0) begin
      errors++; $display("FAIL mis6_we: got %0d write pulses want 0", we_cnt - w0);
    end
    checks++;
    if (word_at(4) !== 32'h04050607 || word_at(8) !== 32'h11223344) begin
      errors++; $display("FAIL mis6_mem: got %h %h want 04050607 11223344", word_at(4), word_at(8));
    end
  endtask

  task automatic test_range();
    int r0c;
    r0c = re_cnt;
    access(0, 1'b0, 32'd254, 32'h0, 1'b1, 32'h0, 1'b1, "rd254");
    access(0, 1'b0, 32'd256, 32'h0, 1'b1, 32'h0, 1'b1, "rd256");
    access(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b1, "rdtop");
    @(posedge clk); #2;
    checks++;
    if (re_cnt !== r0c) begin
      errors++; $display("FAIL range_re: got %0d read pulses want 0", re_cnt - r0c);
    end
    access(0, 1'b0, 32'd252, 32'h0, 1'b0, 32'hFCFDFEFF, 1'b1, "rd252");
  endtask

  task automatic test_round_robin();
    logic [12:0] g0, g1, d0, d1;
    g0 = '0; g1 = '0; d0 = '0; d1 = '0;
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    r0_req = 1; r0_we = 0; r0_addr = 32'd8;
    r1_req = 1; r1_we = 0; r1_addr = 32'd12;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); @(negedge clk);
      g0[i] = r0_gnt; g1[i] = r1_gnt; d0[i] = r0_done; d1[i] = r1_done;
    end
    r0_req = 0; r1_req = 0;
    checks++;
    if (g0 !== 13'b0000010000010 || g1 !== 13'b0010000010000) begin
      errors++; $display("FAIL rr_gnt: got g0=%b g1=%b want 0000010000010 0010000010000", g0, g1);
    end
    checks++;
    if (d0 !== 13'b0000100000100 || d1 !== 13'b0100000100000) begin
      errors++; $display("FAIL rr_done: got d0=%b d1=%b want 0000100000100 0100000100000", d0, d1);
    end
    checks++;
    if (r0_rdata !== 32'h11223344 || r1_rdata !== 32'h0C0D0E0F) begin
      errors++; $display("FAIL rr_rdata: got %h %h want 11223344 0c0d0e0f", r0_rdata, r1_rdata);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    r0_req = 1; r0_we = 1; r0_addr = 32'd16; r0_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst_n = 0; r0_req = 0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_we: got mem_we=%b want 0", mem_we);
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    checks++;
    if ({busy, r0_gnt, r0_done, r0_err, mem_we, mem_re} !== 6'b0 || mem_addr !== 32'h0 || r0_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_idle: got busy=%b gnt=%b done=%b addr=%h rdata=%h want all 0",
        busy, r0_gnt, r0_done, mem_addr, r0_rdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (word_at(16) !== 32'h10111213 || busy !== 1'b0 || r0_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_mem: got word=%h busy=%b want 10111213 0", word_at(16), busy);
    end
  endtask

  task automatic test_cancel();
    int g1c, d1c;
    g1c = gnt1_cnt; d1c = done1_cnt;
    @(posedge clk); #1;
    r0_req = 1; r0_we = 0; r0_addr = 32'd0;
    @(posedge clk); #1;
    r1_req = 1; r1_we = 0; r1_addr = 32'd4;  // raised only during r0's ACCESS
    @(posedge clk); #1;
    r1_req = 0; r0_req = 0;
    @(negedge clk);
    checks++;
    if (r0_done !== 1'b1 || r0_rdata !== 32'h00010203) begin
      errors++; $display("FAIL cancel_r0: got done=%b rdata=%h want 1 00010203", r0_done, r0_rdata);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cancel_busy: got busy=%b want 0", busy);
    end
    @(posedge clk); #2;
    checks++;
    if (gnt1_cnt !== g1c || done1_cnt !== d1c) begin
      errors++; $display("FAIL cancel_r1: got gnt=%0d done=%0d want 0 0", gnt1_cnt - g1c, done1_cnt - d1c);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL exclusive: got %0d cycles with both gnt/done want 0", both_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_range();
    test_round_robin();
    test_reset_mid();
    test_cancel();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (byte-addressed, big-endian, 32-bit word, combinational read, level-enabled write) between two requesters.
- Requester 0 is the pipeline MEM stage; requester 1 is the program/data loader used at boot and for debug.
- Round-robin arbitration, one access at a time, fixed 3-cycle turnaround.
- Flags misaligned or out-of-range word accesses and never forwards them to memory.

Parameters:
- ADDR_W, 32, address width of requesters and memory port
- DATA_W, 32, data width (fixed at 4 bytes, big-endian)
- MEM_BYTES, 256, memory size in bytes; legal word addresses are 0..MEM_BYTES-4

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- r0_req  in  1  requester 0 access request, held until r0_gnt
- r0_we  in  1  requester 0: 1=write, 0=read
- r0_addr  in  ADDR_W  requester 0 byte address
- r0_wdata  in  DATA_W  requester 0 write data
- r0_gnt  out  1  one-cycle pulse: request accepted
- r0_done  out  1  one-cycle pulse: access complete
- r0_rdata  out  DATA_W  read data, valid while r0_done
- r0_err  out  1  error flag, valid while r0_done
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata, r1_err  same as r0_* for requester 1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data (combinational)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low. With rst_n low at an edge:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - All gnt/done/err=0, rdata regs=0, address/data latches=0.
- mem_we and mem_re are combinationally ANDed with rst_n. A reset asserted during ACCESS suppresses that cycle's memory write/read.
- FSM IDLE -> ACCESS -> DONE -> IDLE; no other transitions except reset.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata and error check, then go to ACCESS.
  - Only one request: it wins. Both requesting: winner is the one != last_grant.
- ACCESS (exactly 1 cycle):
  - Winner's gnt=1.
  - mem_addr/mem_wdata come from the latches.
  - If no error: mem_we=latched_we, mem_re=~latched_we. If error: both low.
  - Read data: mem_rdata is captured into the winner's rdata reg at the end of the cycle; otherwise 0 is captured.
  - Go to DONE.
- DONE (1 cycle):
  - Winner's done=1 and err=latched_err; rdata is held.
  - last_grant is updated to the winner.
  - Go to IDLE.
- Outside ACCESS/DONE: mem_we=mem_re=0 and mem_addr=mem_wdata=0.
- Latency:
  - Request sampled at edge k: gnt is high in cycle k+1, done is high in cycle k+2, IDLE again at k+3.
  - Minimum spacing between accesses is 3 cycles.
- The loser keeps req high and is served next, so it waits at most one access.
- rdata holds its last value until that requester's next done; it is undefined for writes and must be ignored.
- Error = addr[1:0]!=0, or addr > MEM_BYTES-4 (unsigned, full ADDR_W compare, no wrap). Errored writes leave memory untouched.
- A requester dropping req after gnt is legal. Dropping req before gnt cancels the request with no side effects.
- Changes to the winner's inputs after the IDLE->ACCESS edge are ignored (latched).
- gnt and done are never high for both requesters in the same cycle.

Test Plan:
- Reset, then write 0x11223344 to addr 8 via r0, then read addr 8 via r0 -> each access: gnt at +1, done at +2. Read returns r0_rdata=0x11223344 with err=0. Memory bytes 8..11 = 11,22,33,44.
- r0 and r1 both request reads from reset, held continuously -> grants go r0, r1, r0, r1, spaced 3 cycles apart; never both gnt in one cycle.
- r1 writes 0xDEADBEEF to addr 6 (misaligned) -> r1_err=1 at done, mem_we never high, bytes 4..11 unchanged.
- r0 reads addr 254 with MEM_BYTES=256 -> r0_err=1, r0_rdata=0, mem_re never high. Then addr 252 -> err=0.
- r0 write in progress, rst_n pulled low during the ACCESS cycle -> mem_we low that cycle, no done pulse. Next cycle: IDLE, busy=0, all outputs 0, target bytes unchanged.
- r1 raises req for one cycle while r0 holds the grant, then drops it -> r1 never granted, no r1_done, busy returns to 0 after r0's DONE.
